// File: rtl/snn_image_loader_if.sv
// Handshake bundle between the image loader and its UART, input-unit RAM and SNN core.
// master = loader side, slave = environment side (UART, RAM, core).
interface snn_image_loader_if #(
    parameter int ADDR_W = 10
);
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              clr_rx_rdy;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_data;
    logic              ram_we;
    logic              start;
    logic              done;
    logic [3:0]        digit;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_done;
    logic              busy;
    logic [2:0]        dbg_state;

    // rx: rx_rdy is a level held by the UART until clr_rx_rdy pulses; the byte
    // transfers in the cycle where both are high. start/tx_start are 1-cycle pulses,
    // done/tx_done are single-cycle acknowledgements that only count in the
    // state that waits for them.
    modport master (
        input  rx_rdy, rx_data, done, digit, tx_done,
        output clr_rx_rdy, ram_addr, ram_data, ram_we, start, tx_start, tx_data,
               busy, dbg_state
    );

    modport slave (
        output rx_rdy, rx_data, done, digit, tx_done,
        input  clr_rx_rdy, ram_addr, ram_data, ram_we, start, tx_start, tx_data,
               busy, dbg_state
    );
endinterface

// File: rtl/snn_image_loader.sv
// Unpacks UART bytes LSB-first into the 1-bit input-unit RAM, kicks the SNN core and
// returns its digit over UART. Define SNN_ASCII_DIGIT_EN to send the digit as ASCII.
module snn_image_loader #(
    parameter int NUM_PIXELS = 784,
    parameter int ADDR_W     = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    snn_image_loader_if.master     bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_UNPACK    = 3'd1,
        S_START     = 3'd2,
        S_WAIT_CORE = 3'd3,
        S_SEND      = 3'd4,
        S_WAIT_TX   = 3'd5
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] pix_cnt_q;
    logic [7:0]        shift_q;
    logic [7:0]        tx_data_q;
    logic [7:0]        tx_code_d;

`ifdef SNN_ASCII_DIGIT_EN
    assign tx_code_d = 8'h30 + {4'h0, bus.digit};
`else
    assign tx_code_d = {4'h0, bus.digit};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pix_cnt_q <= '0;
            shift_q   <= '0;
            tx_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.rx_rdy) begin
                        shift_q <= bus.rx_data;
                        state_q <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    shift_q   <= shift_q >> 1;
                    pix_cnt_q <= pix_cnt_q + ADDR_W'(1);
                    // pix_cnt only ever moves in whole bytes, so its low 3 bits
                    // double as the bit-within-byte counter.
                    if (pix_cnt_q[2:0] == 3'd7) begin
                        state_q <= (pix_cnt_q == LAST_PIX) ? S_START : S_IDLE;
                    end
                end
                S_START: begin
                    pix_cnt_q <= '0;
                    state_q   <= S_WAIT_CORE;
                end
                S_WAIT_CORE: begin
                    if (bus.done) begin
                        tx_data_q <= tx_code_d;
                        state_q   <= S_SEND;
                    end
                end
                S_SEND: begin
                    state_q <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (bus.tx_done) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // clr_rx_rdy acknowledges in the same cycle the byte is latched; it is gated by
    // rst so a byte is never dropped while the FSM is being reset.
    assign bus.clr_rx_rdy = !rst && (state_q == S_IDLE) && bus.rx_rdy;
    assign bus.ram_we     = (state_q == S_UNPACK);
    assign bus.ram_addr   = pix_cnt_q;
    assign bus.ram_data   = shift_q[0];
    assign bus.start      = (state_q == S_START);
    assign bus.tx_start   = (state_q == S_SEND);
    assign bus.tx_data    = tx_data_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.dbg_state  = state_q;
endmodule
